// File: rtl/dmem_port_arbiter.sv
// Shares the single Data_Memory port between the core MEM stage and a burst DMA
// engine. The core normally wins, but it can hold off an eligible DMA beat for
// at most STARVE_LIMIT consecutive grants.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic [63:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_start,
  input  logic        dma_we,
  input  logic [63:0] dma_base,
  input  logic [4:0]  dma_len,
  output logic        dma_busy,
  input  logic [63:0] dma_wdata,
  input  logic        dma_wvalid,
  output logic        dma_wready,
  output logic [63:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [63:0]   addr_reg, addr_next;
  logic [4:0]    remain_reg, remain_next;
  logic          we_reg, we_next;
  logic [63:0]   rdata_reg;
  logic          rvalid_reg;

  logic [4:0] len_clamped;
  logic       cpu_req;
  logic       dma_elig;
  logic       dma_grant;

  assign cpu_req     = cpu_rd | cpu_wr;
  assign len_clamped = (dma_len > 5'd16) ? 5'd16 : dma_len;
  // A write beat only competes for the port once its data is actually present.
  assign dma_elig    = (state_reg == BURST) && (!we_reg || dma_wvalid);
  assign dma_grant   = dma_elig && (!cpu_req || (starve_reg == STARVE_MAX));

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    addr_next   = addr_reg;
    remain_next = remain_reg;
    we_next     = we_reg;
    case (state_reg)
      IDLE: begin
        starve_next = '0;
        if (dma_start) begin
          addr_next   = dma_base;
          remain_next = len_clamped;
          we_next     = dma_we;
          state_next  = (len_clamped == 5'd0) ? DONE : BURST;
        end
      end
      BURST: begin
        if (dma_grant) begin
          starve_next = '0;
          addr_next   = addr_reg + 64'd8;
          remain_next = remain_reg - 5'd1;
          if (remain_reg == 5'd1) begin
            state_next = DONE;
          end
        end else if (dma_elig && (starve_reg != STARVE_MAX)) begin
          starve_next = starve_reg + SW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The port stays quiet while reset is low so an aborted burst cannot write.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (dma_grant) begin
      mem_rd    = !we_reg;
      mem_wr    = we_reg;
      mem_addr  = addr_reg;
      mem_wdata = dma_wdata;
    end else if (reset) begin
      mem_rd = cpu_rd;
      mem_wr = cpu_wr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      starve_reg <= '0;
      addr_reg   <= '0;
      remain_reg <= '0;
      we_reg     <= 1'b0;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      addr_reg   <= addr_next;
      remain_reg <= remain_next;
      we_reg     <= we_next;
      rvalid_reg <= dma_grant && !we_reg;
      if (dma_grant && !we_reg) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = cpu_req && dma_grant;
  assign dma_wready = dma_grant && we_reg;
  assign dma_busy   = (state_reg != IDLE);
  assign dma_done   = (state_reg == DONE);
  assign dma_rdata  = rdata_reg;
  assign dma_rvalid = rvalid_reg;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: burst vector table, hand-written corner sequences
// and randomized traffic, all watched by a queue-based reference model.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_start, dma_we;
  logic [63:0] dma_base;
  logic [4:0]  dma_len;
  logic        dma_busy;
  logic [63:0] dma_wdata;
  logic        dma_wvalid, dma_wready;
  logic [63:0] dma_rdata;
  logic        dma_rvalid, dma_done;
  logic        mem_rd, mem_wr;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  dmem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_start(dma_start), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid),
    .dma_wready(dma_wready), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .dma_done(dma_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // 64-word data memory, aliased on address bits [8:3]
  logic [63:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[8:3]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[8:3]] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a burst is a queue of beat addresses still owed; the core
  // may win at most LIMIT times in a row while the head beat is ready.
  longint unsigned q_addr[$];
  bit              m_we, m_done, m_rv;
  logic [63:0]     m_rdata;
  int              m_wins;

  always @(negedge clk) begin
    bit creq, elig, dg, idle, exp_rd, exp_wr;
    int n;
    longint unsigned a;
    if (reset !== 1'b1) begin
      chkb("rst_dma_busy", dma_busy, 1'b0);
      chkb("rst_dma_done", dma_done, 1'b0);
      chkb("rst_dma_rvalid", dma_rvalid, 1'b0);
      chkb("rst_dma_wready", dma_wready, 1'b0);
      chk("rst_dma_rdata", dma_rdata, 64'd0);
      chkb("rst_mem_wr", mem_wr, 1'b0);
      q_addr.delete();
      m_we = 1'b0; m_done = 1'b0; m_rv = 1'b0; m_rdata = '0; m_wins = 0;
    end else begin
      creq   = cpu_rd | cpu_wr;
      elig   = (q_addr.size() != 0) && (!m_we || dma_wvalid);
      dg     = elig && (!creq || m_wins == LIMIT);
      idle   = (q_addr.size() == 0) && !m_done;
      exp_rd = dg ? !m_we : cpu_rd;
      exp_wr = dg ? m_we : cpu_wr;
      chkb("mem_rd", mem_rd, exp_rd);
      chkb("mem_wr", mem_wr, exp_wr);
      if (exp_rd || exp_wr) chk("mem_addr", mem_addr, dg ? q_addr[0] : cpu_addr);
      if (exp_wr) chk("mem_wdata", mem_wdata, dg ? dma_wdata : cpu_wdata);
      chk("cpu_rdata", cpu_rdata, mem_rdata);
      chkb("cpu_stall", cpu_stall, creq && dg);
      chkb("dma_wready", dma_wready, dg && m_we);
      chkb("dma_busy", dma_busy, !idle);
      chkb("dma_done", dma_done, m_done);
      chkb("dma_rvalid", dma_rvalid, m_rv);
      if (m_rv) chk("dma_rdata", dma_rdata, m_rdata);
      // advance to the next cycle
      m_rv = dg && !m_we;
      if (m_rv) begin
        a = q_addr[0];
        m_rdata = mem[a[8:3]];
      end
      m_done = 1'b0;
      if (dg) begin
        void'(q_addr.pop_front());
        m_wins = 0;
        if (q_addr.size() == 0) m_done = 1'b1;
      end else if (elig) begin
        if (m_wins < LIMIT) m_wins++;
      end
      if (idle) begin
        m_wins = 0;
        if (dma_start) begin
          n = (dma_len > 5'd16) ? 16 : int'(dma_len);
          for (int i = 0; i < n; i++) q_addr.push_back(dma_base + 64'(8 * i));
          m_we = dma_we;
          if (n == 0) m_done = 1'b1;
        end
      end
    end
  end

  // Per-scenario observations, gathered once per cycle at the falling edge
  int          cyc, n_rd, n_wr, n_rv, n_wready, n_done, bad_wready, first_rv, last_rv, done_cyc;
  logic [63:0] acc_addr[$];
  int          stall_cyc[$];

  task automatic clear_obs();
    cyc = -1; n_rd = 0; n_wr = 0; n_rv = 0; n_wready = 0; n_done = 0; bad_wready = 0;
    first_rv = -1; last_rv = -1; done_cyc = -1;
    acc_addr.delete();
    stall_cyc.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_rd) begin n_rd++; acc_addr.push_back(mem_addr); end
    if (mem_wr) begin n_wr++; if (!mem_rd) acc_addr.push_back(mem_addr); end
    if (dma_rvalid) begin n_rv++; if (first_rv < 0) first_rv = cyc; last_rv = cyc; end
    if (dma_wready) n_wready++;
    if (dma_wready && !dma_wvalid) bad_wready++;
    if (cpu_stall) stall_cyc.push_back(cyc);
    if (dma_done) begin n_done++; done_cyc = cyc; end
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input bit we, input logic [63:0] base, input logic [4:0] len);
    dma_start = 1'b1; dma_we = we; dma_base = base; dma_len = len;
    tick();
    dma_start = 1'b0;
  endtask

  typedef struct {
    bit rd; bit wr; logic [63:0] addr; logic [63:0] wdata;
    bit exp_rd; bit exp_wr; bit exp_stall; logic [63:0] exp_rdata;
  } arb_vec_t;

  typedef struct {
    bit we; logic [63:0] base; logic [4:0] len; int beats; int done_at;
  } burst_vec_t;

  arb_vec_t   av [4];
  burst_vec_t bv [6];
  bit         wv [8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_start = 1'b0; dma_we = 1'b0; dma_base = '0; dma_len = '0;
    dma_wdata = '0; dma_wvalid = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 64'hA5A5_0000_0000_0000 + 64'(i);

    av[0] = '{1'b1, 1'b0, 64'h10, 64'h0,    1'b1, 1'b0, 1'b0, 64'hA5A5_0000_0000_0002};
    av[1] = '{1'b0, 1'b1, 64'h18, 64'h1111, 1'b0, 1'b1, 1'b0, 64'hA5A5_0000_0000_0003};
    av[2] = '{1'b1, 1'b1, 64'h20, 64'h2222, 1'b1, 1'b1, 1'b0, 64'hA5A5_0000_0000_0004};
    av[3] = '{1'b0, 1'b0, 64'h28, 64'h0,    1'b0, 1'b0, 1'b0, 64'hA5A5_0000_0000_0005};

    bv[0] = '{1'b0, 64'h0,                   5'd5,  5,  6};
    bv[1] = '{1'b0, 64'h40,                  5'd0,  0,  1};
    bv[2] = '{1'b1, 64'h100,                 5'd31, 16, 17};
    bv[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 5'd2,  2,  3};
    bv[4] = '{1'b1, 64'h40,                  5'd16, 16, 17};
    bv[5] = '{1'b0, 64'h8,                   5'd1,  1,  2};

    wv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (3) begin
      @(negedge clk);
      chkb("reset_busy", dma_busy, 1'b0);
      chkb("reset_done", dma_done, 1'b0);
      chk("reset_rdata", dma_rdata, 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // Core-only arbitration while the DMA is idle
    for (int v = 0; v < 4; v++) begin
      cpu_rd = av[v].rd; cpu_wr = av[v].wr; cpu_addr = av[v].addr; cpu_wdata = av[v].wdata;
      @(negedge clk);
      chkb("arb_mem_rd", mem_rd, av[v].exp_rd);
      chkb("arb_mem_wr", mem_wr, av[v].exp_wr);
      chkb("arb_stall", cpu_stall, av[v].exp_stall);
      chk("arb_cpu_rdata", cpu_rdata, av[v].exp_rdata);
      $display("core rd=%b wr=%b addr=0x%0h rdata=0x%0h", cpu_rd, cpu_wr, cpu_addr, cpu_rdata);
      @(posedge clk); #1;
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    chk("arb_store", mem[3], 64'h1111);
    chk("arb_rdwr_store", mem[4], 64'h2222);

    // Burst table with no core traffic
    for (int v = 0; v < 6; v++) begin
      clear_obs();
      dma_wvalid = bv[v].we;
      dma_wdata = 64'hC0DE_0000_0000_0000 | 64'(v);
      start_burst(bv[v].we, bv[v].base, bv[v].len);
      for (int k = 0; k < 40 && n_done == 0; k++) tick();
      tick(); tick();
      dma_wvalid = 1'b0;
      chk_int("burst_beats", bv[v].we ? n_wr : n_rd, bv[v].beats);
      chk_int("burst_other_dir", bv[v].we ? n_rd : n_wr, 0);
      for (int i = 0; i < acc_addr.size(); i++)
        chk("burst_addr", acc_addr[i], bv[v].base + 64'(8 * i));
      chk_int("burst_done_count", n_done, 1);
      chk_int("burst_done_cycle", done_cyc, bv[v].done_at);
      if (bv[v].we) begin
        chk_int("burst_wready", n_wready, bv[v].beats);
        chk_int("burst_no_rvalid", n_rv, 0);
      end else begin
        chk_int("burst_rvalid", n_rv, bv[v].beats);
        if (bv[v].beats > 0) begin
          chk_int("burst_first_rvalid", first_rv, 2);
          chk_int("burst_last_rvalid", last_rv, bv[v].done_at);
        end
      end
      $display("burst %0d we=%0d base=0x%0h len=%0d beats=%0d done@%0d",
               v, bv[v].we, bv[v].base, bv[v].len, bv[v].we ? n_wr : n_rd, done_cyc);
    end

    // Write burst with write data withheld for two cycles mid-burst
    clear_obs();
    dma_wvalid = 1'b0;
    start_burst(1'b1, 64'h80, 5'd3);
    for (int k = 1; k <= 8; k++) begin
      dma_wvalid = wv[k-1];
      dma_wdata = 64'hD000 + 64'(k);
      tick();
    end
    dma_wvalid = 1'b0;
    chk_int("gap_writes", n_wr, 3);
    chk_int("gap_wready", n_wready, 3);
    chk_int("gap_wready_no_valid", bad_wready, 0);
    chk_int("gap_done_cycle", done_cyc, 6);
    chk("gap_beat0", mem[16], 64'hD001);
    chk("gap_beat1", mem[17], 64'hD004);
    chk("gap_beat2", mem[18], 64'hD005);
    $display("wgap burst writes=%0d wready=%0d done@%0d", n_wr, n_wready, done_cyc);

    // Core loads every cycle against a 2-beat read burst
    clear_obs();
    cpu_rd = 1'b1; cpu_addr = 64'h1F0;
    start_burst(1'b0, 64'h0, 5'd2);
    for (int k = 0; k < 13; k++) tick();
    cpu_rd = 1'b0;
    chk_int("starve_dma_grants", stall_cyc.size(), 2);
    chk_int("starve_first_grant", stall_cyc.size() > 0 ? stall_cyc[0] : -1, 5);
    chk_int("starve_second_grant", stall_cyc.size() > 1 ? stall_cyc[1] : -1, 10);
    chk_int("starve_done_cycle", done_cyc, 11);
    chk_int("starve_last_rvalid", last_rv, 11);
    chk_int("starve_rvalid", n_rv, 2);
    $display("starve burst dma_grants=%0d done@%0d", stall_cyc.size(), done_cyc);

    // Reset after the second beat of a 6-beat write burst
    clear_obs();
    dma_wvalid = 1'b1; dma_wdata = 64'hBEEF;
    start_burst(1'b1, 64'h1C0, 5'd6);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk_int("abort_writes", n_wr, 2);
    chk("abort_untouched", mem[58], 64'hA5A5_0000_0000_003A);
    reset = 1'b1; dma_wvalid = 1'b0;
    repeat (4) tick();
    chk_int("abort_no_done", n_done, 0);
    chkb("abort_idle", dma_busy, 1'b0);
    $display("abort burst writes=%0d done_pulses=%0d", n_wr, n_done);
    clear_obs();
    start_burst(1'b0, 64'h1C0, 5'd2);
    for (int k = 0; k < 10 && n_done == 0; k++) tick();
    tick();
    chk_int("restart_reads", n_rd, 2);
    chk_int("restart_rvalid", n_rv, 2);
    chk_int("restart_done_cycle", done_cyc, 3);
    chk("restart_rdata", dma_rdata, 64'hBEEF);
    $display("restart burst reads=%0d done@%0d", n_rd, done_cyc);

    // Randomized traffic, checked by the reference model each cycle
    for (int c = 0; c < 400; c++) begin
      cpu_rd     = ($urandom_range(0, 3) < ((c < 200) ? 1 : 3));
      cpu_wr     = ($urandom_range(0, 5) == 0);
      cpu_addr   = 64'($urandom_range(0, 63)) << 3;
      cpu_wdata  = {$urandom, $urandom};
      dma_start  = ($urandom_range(0, 9) == 0);
      dma_we     = 1'($urandom_range(0, 1));
      dma_len    = 5'($urandom_range(0, 31));
      dma_base   = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFE0
                                               : 64'($urandom_range(0, 63)) << 3;
      dma_wvalid = ($urandom_range(0, 3) != 0);
      dma_wdata  = {$urandom, $urandom};
      reset      = ($urandom_range(0, 199) != 0);
      tick();
      if (dma_start) $display("random start cycle=%0d we=%0d base=0x%0h len=%0d",
                              c, dma_we, dma_base, dma_len);
    end
    reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; dma_start = 1'b0; dma_wvalid = 1'b0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive core grants while a DMA beat is eligible.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  MEM-stage load request.
- cpu_wr  in  1  MEM-stage store request.
- cpu_addr  in  64  core byte address.
- cpu_wdata  in  64  core store data.
- cpu_rdata  out  64  core load data.
- cpu_stall  out  1  core request not granted this cycle; freezes the pipeline.
- dma_start  in  1  one-cycle burst start pulse.
- dma_we  in  1  burst direction, sampled on dma_start: 1 = write memory, 0 = read memory.
- dma_base  in  64  burst start address, sampled on dma_start.
- dma_len  in  5  beat count, sampled on dma_start.
- dma_busy  out  1  burst in progress.
- dma_wdata  in  64  write-beat data.
- dma_wvalid  in  1  write-beat data valid.
- dma_wready  out  1  write beat accepted this cycle.
- dma_rdata  out  64  registered read-beat data.
- dma_rvalid  out  1  dma_rdata valid, one-cycle pulse.
- dma_done  out  1  burst complete, one-cycle pulse.
- mem_rd  out  1  Data_Memory MemRead.
- mem_wr  out  1  Data_Memory MemWrite; the memory writes on the clock edge.
- mem_addr  out  64  Data_Memory address.
- mem_wdata  out  64  Data_Memory write data.
- mem_rdata  in  64  Data_Memory combinational read data.

Function
REQ-003 SHALL implement FSM states IDLE, BURST and DONE:
- IDLE->BURST on dma_start with clamped length nonzero.
- IDLE->DONE on dma_start with dma_len = 0; no memory access occurs.
- BURST->DONE on the cycle the last beat is granted.
- DONE->IDLE unconditionally after one cycle.
REQ-004 SHALL clamp dma_len values above 16 to 16; the valid burst range is 1..16 beats.
REQ-005 SHALL ignore dma_start outside IDLE.
REQ-006 SHALL define the DMA beat as eligible when in BURST AND (read burst OR dma_wvalid = 1).
REQ-007 SHALL define cpu_req = cpu_rd | cpu_wr.
REQ-008 SHALL grant the DMA beat when it is eligible AND (cpu_req = 0 OR starve_cnt = STARVE_LIMIT); otherwise the core is granted.
REQ-009 SHALL make grant a purely combinational function of the current inputs and registered state, so a core access needs no extra cycle when granted.
REQ-010 SHALL drive the memory port from the grant winner:
- Core granted: mem_rd/mem_wr/mem_addr/mem_wdata = cpu_rd/cpu_wr/cpu_addr/cpu_wdata.
- DMA granted: mem_rd = !we, mem_wr = we, mem_addr = current beat address, mem_wdata = dma_wdata.
- No request: mem_rd = mem_wr = 0.
REQ-011 SHALL assign cpu_rdata = mem_rdata combinationally at all times.
REQ-012 SHALL assert cpu_stall = cpu_req AND DMA granted.
REQ-013 SHALL update starve_cnt as follows:
- Increments, saturating at STARVE_LIMIT, on each cycle the DMA beat is eligible and the core is granted.
- Clears on a DMA grant and in IDLE.
- Holds otherwise.
REQ-014 SHALL advance the beat address by 8 per DMA grant, wrapping modulo 2^64, and decrement the beats-remaining counter by 1 per DMA grant.
REQ-015 SHALL assert dma_wready = DMA granted AND we, in the same cycle as dma_wvalid.
REQ-016 SHALL, on each read-beat grant, register mem_rdata into dma_rdata and pulse dma_rvalid in the following cycle.
REQ-017 SHALL assert dma_busy in BURST and DONE.
REQ-018 SHALL assert dma_done only in DONE, i.e. one cycle after the last grant; for a read burst this coincides with the final dma_rvalid.
REQ-019 SHALL resolve cpu_rd and cpu_wr both asserted as a core store that also returns mem_rdata.

Reset
REQ-020 SHALL, while reset = 0, set the FSM to IDLE, clear starve_cnt, the beat address and the beats-remaining counter, and drive dma_busy, dma_done, dma_rvalid and dma_wready to 0 and dma_rdata to 0.
REQ-021 SHALL, when reset is asserted mid-burst, abort the burst without pulsing dma_done; no further memory write occurs from the first cycle reset is low.

Verification
REQ-022 Bench SHALL cover: read burst, base 0x0, dma_len = 5, no core traffic -> five consecutive grants at addresses 0x0..0x20; dma_rvalid on cycles 2..6; dma_done on cycle 6.
REQ-023 Bench SHALL cover: write burst, dma_len = 3, dma_wvalid low for 2 cycles mid-burst -> dma_wready only when dma_wvalid = 1; exactly 3 memory writes; dma_done one cycle after the 3rd.
REQ-024 Bench SHALL cover: core loads every cycle during a read burst of 2, STARVE_LIMIT = 4 -> pattern of 4 core grants, 1 DMA grant (cpu_stall = 1), repeated; done after the 2nd DMA grant.
REQ-025 Bench SHALL cover: dma_len = 0 -> dma_done one cycle after start; mem_rd = mem_wr = 0 throughout. dma_len = 31 -> exactly 16 beats.
REQ-026 Bench SHALL cover: base 0xFFFF_FFFF_FFFF_FFF8, dma_len = 2 -> beat addresses 0xFFFF_FFFF_FFFF_FFF8 then 0x0.
REQ-027 Bench SHALL cover: reset low after the 2nd beat of a 6-beat write burst -> all outputs reset, dma_done never pulses, a new dma_start after release runs normally.
